cu_multicycle: RTL and testbench

- Parametrised successor to the fixed 8-bit control unit: a multi-cycle FETCH/DECODE/EXEC/WB sequencer with its own 4-entry register file, ALU and zero/carry flags.
- Adds parametrised data and PC widths, a req/ack instruction-memory handshake with wait states, an external stall input, jumps and a sticky halt.
- Sits between instruction memory and the top-level processor; debug outputs pc_out, alu_result, state and hold keep the existing waveform-bench style.

---
 rtl/cu_multicycle_if.sv | 15 +
 rtl/cu_multicycle.sv | 162 ++++++++++++++++
 tb/tb_cu_multicycle.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_multicycle_if.sv
// Instruction-memory request/acknowledge bus between the control unit (master) and imem (slave).
interface cu_multicycle_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 16
);
    localparam int unsigned INSTR_W = DATA_W + 6;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/cu_multicycle.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit with a 4-entry register file, ALU, Z/C flags,
// imem req/ack fetch, external stall and sticky halt.
module cu_multicycle #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    cu_multicycle_if.master   imem,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] alu_result,
    output logic [2:0]        state,
    output logic              hold,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              illegal
);
    localparam int unsigned INSTR_W = DATA_W + 6;
    localparam int unsigned NREG    = 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADDI = 4'd2;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_HLT  = 4'd15;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  opnd_q, opnd_d;
    logic [DATA_W-1:0]  alu_q, alu_d;
    logic               z_q, z_d, c_q, c_d, ill_q, ill_d;
    logic [DATA_W-1:0]  regs_q [NREG];
    logic [DATA_W-1:0]  regs_d [NREG];

    logic [3:0]         op;
    logic [1:0]         rd;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W-1:0]  res;
    logic               res_v;
    logic [DATA_W:0]    sum;

    assign op  = ir_q[INSTR_W-1 -: 4];
    assign rd  = ir_q[DATA_W +: 2];
    assign imm = ir_q[DATA_W-1:0];

    // Next-state and datapath update; every stage holds its registers by default.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        opnd_d  = opnd_q;
        alu_d   = alu_q;
        z_d     = z_q;
        c_d     = c_q;
        ill_d   = ill_q;
        regs_d  = regs_q;
        res     = '0;
        res_v   = 1'b0;
        sum     = '0;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opnd_d  = regs_q[rd];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (op)
                    OP_LDI:  begin res = imm; res_v = 1'b1; end
                    OP_ADDI: begin
                        sum   = {1'b0, opnd_q} + {1'b0, imm};
                        res   = sum[DATA_W-1:0];
                        c_d   = sum[DATA_W];
                        res_v = 1'b1;
                    end
                    OP_SUBI: begin
                        sum   = {1'b0, opnd_q} - {1'b0, imm};
                        res   = sum[DATA_W-1:0];
                        c_d   = sum[DATA_W];
                        res_v = 1'b1;
                    end
                    OP_AND:  begin res = opnd_q & imm; c_d = 1'b0; res_v = 1'b1; end
                    OP_OR:   begin res = opnd_q | imm; c_d = 1'b0; res_v = 1'b1; end
                    OP_XOR:  begin res = opnd_q ^ imm; c_d = 1'b0; res_v = 1'b1; end
                    OP_MOV:  begin res = regs_q[0]; res_v = 1'b1; end
                    4'd10, 4'd11, 4'd12, 4'd13, 4'd14: ill_d = 1'b1;
                    default: ;
                endcase
                if (res_v) begin
                    alu_d = res;
                    z_d   = (res == '0);
                end
            end
            S_WB: begin
                pc_d = pc_q + PC_W'(1);
                if ((op >= OP_LDI) && (op <= OP_MOV)) regs_d[rd] = alu_q;
                if ((op == OP_JMP) || ((op == OP_JZ) && z_q)) pc_d = PC_W'(imm);
                state_d = (op == OP_HLT) ? S_HALT : S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          state_q <= S_FETCH;
        else if (!stall_in) state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q   <= '0;
            ir_q   <= '0;
            opnd_q <= '0;
            alu_q  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            ill_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (!stall_in) begin
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            opnd_q <= opnd_d;
            alu_q  <= alu_d;
            z_q    <= z_d;
            c_q    <= c_d;
            ill_q  <= ill_d;
            regs_q <= regs_d;
        end
    end

    // Request is gated by reset so an abandoned fetch drops immediately.
    assign imem.imem_req  = (state_q == S_FETCH) & ~reset;
    assign imem.imem_addr = pc_q;
    assign pc_out         = pc_q;
    assign alu_result     = alu_q;
    assign state          = state_q;
    assign zero_flag      = z_q;
    assign carry_flag     = c_q;
    assign illegal        = ill_q;
    assign hold           = stall_in | ((state_q == S_FETCH) & ~imem.imem_ack) | (state_q == S_HALT);
endmodule

// File: tb/tb_cu_multicycle.sv
// Scoreboard bench for cu_multicycle: an ISA-level model predicts per-instruction results,
// which are compared as each instruction retires.
`timescale 1ns/1ps
module tb_cu_multicycle;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 16;
    localparam int unsigned IW = DW + 6;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] alu;
        logic          z;
        logic          c;
        logic          ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, rst2, stall2;
    logic [PW-1:0] pc;
    logic [DW-1:0] alu;
    logic [2:0]    st;
    logic          hold, z, c, ill;
    logic [3:0]    pc2, alu2;
    logic [2:0]    st2;
    logic          hold2, z2, c2, ill2;

    cu_multicycle_if #(.DATA_W(DW), .PC_W(PW)) bus ();
    cu_multicycle_if #(.DATA_W(4), .PC_W(4)) bus2 ();

    cu_multicycle #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk(clk), .reset(rst), .stall_in(stall), .imem(bus),
        .pc_out(pc), .alu_result(alu), .state(st), .hold(hold),
        .zero_flag(z), .carry_flag(c), .illegal(ill));

    cu_multicycle #(.DATA_W(4), .PC_W(4)) dut2 (
        .clk(clk), .reset(rst2), .stall_in(stall2), .imem(bus2),
        .pc_out(pc2), .alu_result(alu2), .state(st2), .hold(hold2),
        .zero_flag(z2), .carry_flag(c2), .illegal(ill2));

    logic [IW-1:0] mem  [0:255];
    logic [9:0]    mem2 [0:15];

    logic [DW-1:0] m_regs [4];
    logic [DW-1:0] m_alu;
    logic [PW-1:0] m_pc;
    logic          m_z, m_c, m_ill;
    exp_t          exp_q [$];

    int passed, total;
    int waits, wcnt;

    logic [2:0]    tr_st   [0:63];
    logic          tr_hold [0:63];
    logic          tr_ack  [0:63];
    logic [PW-1:0] tr_addr [0:63];

    function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm);
        return {op, rd, imm};
    endfunction

    // Memory slave: acks after 'waits' request cycles, re-acks while req stays high.
    task automatic mem_respond();
        if (bus.imem_req) begin
            if (wcnt >= waits) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem[bus.imem_addr[7:0]];
            end else begin
                bus.imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wcnt = 0;
        end
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = mem2[bus2.imem_addr];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_respond();
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_alu = '0; m_pc = '0; m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [IW-1:0] w;
        logic [3:0]    op;
        logic [1:0]    rd;
        logic [DW-1:0] imm, r;
        int            a, s;
        bit            wr;
        w   = mem[m_pc[7:0]];
        op  = w[IW-1 -: 4];
        rd  = w[DW +: 2];
        imm = w[DW-1:0];
        a   = int'(m_regs[rd]);
        wr  = 1'b1;
        r   = '0;
        case (op)
            4'd1: r = imm;
            4'd2: begin s = a + int'(imm); m_c = (s >= (1 << DW)); r = DW'(s); end
            4'd3: begin m_c = (a < int'(imm)); r = DW'(a - int'(imm)); end
            4'd4: begin r = m_regs[rd] & imm; m_c = 1'b0; end
            4'd5: begin r = m_regs[rd] | imm; m_c = 1'b0; end
            4'd6: begin r = m_regs[rd] ^ imm; m_c = 1'b0; end
            4'd7: r = m_regs[0];
            default: wr = 1'b0;
        endcase
        if (op >= 4'd10 && op <= 4'd14) m_ill = 1'b1;
        if (wr) begin
            m_regs[rd] = r;
            m_alu      = r;
            m_z        = (r == '0);
        end
        if (op == 4'd8 || (op == 4'd9 && m_z)) m_pc = PW'(imm);
        else                                   m_pc = m_pc + PW'(1);
        exp_q.push_back(exp_t'({m_pc, m_alu, m_z, m_c, m_ill}));
    endtask

    // Predict n instructions, then clock the DUT and compare each one as it leaves WB.
    task automatic run_prog(input string tag, input int n, input logic [63:0] smask, output int cyc);
        int         done;
        logic [2:0] prev;
        exp_t       e, got;
        for (int i = 0; i < n; i++) model_step();
        wcnt = 0;
        mem_respond();
        #1;
        cyc  = 0;
        done = 0;
        while (done < n && cyc < 60) begin
            stall = smask[cyc];
            #1;
            tr_st[cyc]   = st;
            tr_hold[cyc] = hold;
            tr_ack[cyc]  = bus.imem_ack;
            tr_addr[cyc] = bus.imem_addr;
            prev = st;
            tick();
            cyc++;
            if (prev == 3'd3 && st != 3'd3) begin
                e   = exp_q.pop_front();
                got = exp_t'({pc, alu, z, c, ill});
                total++;
                if (got !== e)
                    $display("FAIL %s instr%0d pc/alu/z/c/ill: actual %h/%h/%b/%b/%b required %h/%h/%b/%b/%b",
                             tag, done, got.pc, got.alu, got.z, got.c, got.ill, e.pc, e.alu, e.z, e.c, e.ill);
                else passed++;
                done++;
            end
        end
        stall = 1'b0;
        if (done < n) begin
            total++;
            $display("FAIL %s timeout: retired %0d required %0d", tag, done, n);
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({st, pc, alu, z, c, ill} !== '0)
            $display("FAIL reset_state: actual st=%0d pc=%h alu=%h z=%b c=%b ill=%b required all 0", st, pc, alu, z, c, ill);
        else passed++;
        total++;
        if (bus.imem_req !== 1'b0) $display("FAIL reset_req: actual %b required 0", bus.imem_req);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        mem_respond();
        #1;
        total++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0)
            $display("FAIL reset_fetch: actual req=%b addr=%h required req=1 addr=0", bus.imem_req, bus.imem_addr);
        else passed++;
        model_reset();
    endtask

    task automatic test_basic();
        int cyc;
        bit bad;
        mem[0] = ins(4'd1, 2'd1, 8'h05);
        mem[1] = ins(4'd2, 2'd1, 8'hFB);
        mem[2] = ins(4'd5, 2'd1, 8'h00);
        run_prog("basic", 2, 64'h0, cyc);
        total++;
        if (cyc !== 8) $display("FAIL basic_cycles: actual %0d required 8", cyc);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if (tr_st[i] !== 3'(i % 4)) bad = 1'b1;
        total++;
        if (bad) $display("FAIL basic_state_seq: actual %0d%0d%0d%0d%0d%0d%0d%0d required 01230123",
                          tr_st[0], tr_st[1], tr_st[2], tr_st[3], tr_st[4], tr_st[5], tr_st[6], tr_st[7]);
        else passed++;
        run_prog("basic_readback", 1, 64'h0, cyc);
    endtask

    task automatic test_wait();
        int            cyc, hc;
        bit            bad;
        logic [PW-1:0] base;
        base = m_pc;
        waits = 3;
        mem[base[7:0]]      = ins(4'd1, 2'd2, 8'hAA);
        mem[base[7:0] + 1]  = ins(4'd5, 2'd2, 8'h00);
        run_prog("wait", 1, 64'h0, cyc);
        total++;
        if (cyc !== 7) $display("FAIL wait_cycles: actual %0d required 7", cyc);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (tr_st[i] !== 3'd0 || tr_addr[i] !== base) bad = 1'b1;
        total++;
        if (bad) $display("FAIL wait_addr_held: actual addr %h,%h,%h,%h required %h", tr_addr[0], tr_addr[1], tr_addr[2], tr_addr[3], base);
        else passed++;
        hc = 0;
        for (int i = 0; i < 7; i++) if (tr_hold[i] === 1'b1) hc++;
        total++;
        if (hc !== 3) $display("FAIL wait_hold_count: actual %0d required 3", hc);
        else passed++;
        run_prog("wait_readback", 1, 64'h0, cyc);
        waits = 0;
    endtask

    task automatic test_jump();
        int            cyc;
        logic [PW-1:0] base;
        base = m_pc;
        mem[base[7:0]] = ins(4'd8, 2'd0, 8'h20);
        mem[8'h20]     = ins(4'd3, 2'd0, 8'h00);
        mem[8'h21]     = ins(4'd9, 2'd0, 8'h40);
        mem[8'h40]     = ins(4'd1, 2'd3, 8'h01);
        mem[8'h41]     = ins(4'd9, 2'd0, 8'h80);
        run_prog("jump", 5, 64'h0, cyc);
    endtask

    task automatic test_alu_ops();
        int         cyc;
        logic [7:0] b;
        b = m_pc[7:0];
        mem[b]     = ins(4'd1, 2'd3, 8'hF0);
        mem[b + 1] = ins(4'd4, 2'd3, 8'h3C);
        mem[b + 2] = ins(4'd5, 2'd3, 8'h0F);
        mem[b + 3] = ins(4'd6, 2'd3, 8'h3F);
        mem[b + 4] = ins(4'd3, 2'd3, 8'h01);
        mem[b + 5] = ins(4'd2, 2'd3, 8'h01);
        mem[b + 6] = ins(4'd4, 2'd3, 8'hFF);
        mem[b + 7] = ins(4'd1, 2'd0, 8'h5A);
        mem[b + 8] = ins(4'd7, 2'd2, 8'h00);
        run_prog("alu", 9, 64'h0, cyc);
    endtask

    task automatic test_stall();
        int         cyc;
        bit         bad;
        logic [2:0] exp_tr [0:10];
        logic [7:0] b;
        b = m_pc[7:0];
        mem[b]     = ins(4'd1, 2'd1, 8'h11);
        mem[b + 1] = ins(4'd2, 2'd1, 8'h22);
        exp_tr = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        run_prog("stall", 2, 64'h4C, cyc);
        total++;
        if (cyc !== 11) $display("FAIL stall_cycles: actual %0d required 11", cyc);
        else passed++;
        bad = 1'b0;
        for (int i = 0; i < 11; i++) if (tr_st[i] !== exp_tr[i]) bad = 1'b1;
        total++;
        if (bad) $display("FAIL stall_state_seq: actual %0d%0d%0d%0d%0d%0d%0d%0d%0d%0d%0d required 01222300123",
                          tr_st[0], tr_st[1], tr_st[2], tr_st[3], tr_st[4], tr_st[5],
                          tr_st[6], tr_st[7], tr_st[8], tr_st[9], tr_st[10]);
        else passed++;
        total++;
        if (tr_ack[6] !== 1'b1 || tr_hold[6] !== 1'b1 || tr_hold[2] !== 1'b1 || tr_addr[6] !== tr_addr[7])
            $display("FAIL stall_ack_ignored: actual ack6=%b hold6=%b hold2=%b addr6=%h addr7=%h required 1/1/1/equal",
                     tr_ack[6], tr_hold[6], tr_hold[2], tr_addr[6], tr_addr[7]);
        else passed++;
    endtask

    task automatic test_illegal_halt();
        int            cyc;
        bit            bad;
        logic [PW-1:0] pcs;
        logic [7:0]    b;
        b = m_pc[7:0];
        mem[b]     = ins(4'd12, 2'd0, 8'h00);
        mem[b + 1] = ins(4'd15, 2'd0, 8'h00);
        run_prog("illegal_halt", 2, 64'h0, cyc);
        pcs = pc;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (st !== 3'd4 || hold !== 1'b1 || bus.imem_req !== 1'b0 || pc !== pcs || ill !== 1'b1) bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL halt_frozen: actual st=%0d hold=%b req=%b ill=%b required 4/1/0/1", st, hold, bus.imem_req, ill);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (st !== 3'd0 || pc !== '0 || ill !== 1'b0)
            $display("FAIL halt_reset: actual st=%0d pc=%h ill=%b required 0/0/0", st, pc, ill);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid();
        int cyc;
        mem[0] = ins(4'd1, 2'd1, 8'h55);
        mem[1] = ins(4'd1, 2'd2, 8'h66);
        run_prog("pre_reset", 1, 64'h0, cyc);
        for (int i = 0; i < 10 && st !== 3'd1; i++) tick();
        total++;
        if (st !== 3'd1) $display("FAIL reach_decode: actual %0d required 1", st);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({st, pc, alu, z, c, ill} !== '0 || bus.imem_req !== 1'b0)
            $display("FAIL reset_mid: actual st=%0d pc=%h alu=%h z=%b req=%b required all 0", st, pc, alu, z, bus.imem_req);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem[0] = ins(4'd5, 2'd1, 8'h00);
        run_prog("reset_regs", 1, 64'h0, cyc);
    endtask

    task automatic test_pc_wrap();
        mem2[0]  = {4'd8, 2'd0, 4'hF};
        mem2[15] = '0;
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        mem_respond();
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (pc2 !== 4'hF || st2 !== 3'd0 || bus2.imem_addr !== 4'hF)
            $display("FAIL wrap_jmp: actual pc=%h st=%0d required pc=f st=0", pc2, st2);
        else passed++;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (pc2 !== 4'h0 || st2 !== 3'd0 || {alu2, z2, c2, ill2, hold2} !== '0)
            $display("FAIL wrap_nop: actual pc=%h st=%0d alu=%h z=%b c=%b ill=%b hold=%b required pc=0 rest 0",
                     pc2, st2, alu2, z2, c2, ill2, hold2);
        else passed++;
    endtask

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; stall2 = 1'b0;
        waits = 0; wcnt = 0;
        bus.imem_ack = 1'b0;  bus.imem_rdata = '0;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem2[i] = '0;
        model_reset();
        test_reset();
        test_basic();
        test_wait();
        test_jump();
        test_alu_ops();
        test_stall();
        test_illegal_halt();
        test_reset_mid();
        test_pc_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
